// File: rtl/weight_rom_arbiter.sv
// Two-port arbiter for the shared weight ROM read port: round-robin ownership with
// burst locking and a starvation cap, registered ROM reads, tagged in-order returns.
module weight_rom_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 192,
  parameter int ROM_LAT   = 1,
  parameter int ROM_DEPTH = 453,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rdata,
  output logic              err_range
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam int DEPTH_CLAMP = (ROM_DEPTH > 2**ADDR_W) ? 2**ADDR_W : ROM_DEPTH;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH_CLAMP);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               err_q, err_d;
  logic [ROM_LAT:0]   tag_v_q, tag_v_d;
  logic [ROM_LAT:0]   tag_q, tag_d;

  logic [1:0]         req_v;
  logic [1:0]         gnt_v;
  logic               cur;
  logic               take;
  logic               sel;
  logic [ADDR_W-1:0]  acc_addr;

  always_comb begin
    req_v   = {req1, req0};
    cur     = (state_q == OWN1);
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    take    = 1'b0;
    sel     = cur;
    case (state_q)
      IDLE: begin
        if (|req_v) begin
          take    = 1'b1;
          sel     = (&req_v) ? rr_q : req_v[1];
          state_d = sel ? OWN1 : OWN0;
          cnt_d   = CNT_W'(1);
        end
      end
      OWN0, OWN1: begin
        if (req_v[cur]) begin
          take = 1'b1;
          if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (req_v[~cur]) begin
            // Burst cap reached with the other port waiting: hand over with no bubble.
            sel     = ~cur;
            state_d = cur ? OWN0 : OWN1;
            cnt_d   = CNT_W'(1);
            rr_d    = cur;
          end
        end else begin
          rr_d = ~cur;
          if (req_v[~cur]) begin
            take    = 1'b1;
            sel     = ~cur;
            state_d = cur ? OWN0 : OWN1;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    gnt_v      = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
    acc_addr   = sel ? addr1 : addr0;
    rom_en_d   = take;
    rom_addr_d = take ? acc_addr : rom_addr_q;
    err_d      = err_q | (take && ({1'b0, acc_addr} >= DEPTH_LIM));
    // Tag pipeline is one stage deeper than the ROM so its output lines up with rom_data.
    tag_v_d    = {tag_v_q[ROM_LAT-1:0], take};
    tag_d      = {tag_q[ROM_LAT-1:0], sel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      err_q      <= 1'b0;
      tag_v_q    <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      err_q      <= err_d;
      tag_v_q    <= tag_v_d;
      tag_q      <= tag_d;
    end
  end

  assign gnt0      = gnt_v[0] & rst_n;
  assign gnt1      = gnt_v[1] & rst_n;
  assign rvalid0   = tag_v_q[ROM_LAT] & ~tag_q[ROM_LAT];
  assign rvalid1   = tag_v_q[ROM_LAT] & tag_q[ROM_LAT];
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rdata     = rom_data;
  assign err_range = err_q;

endmodule

// File: tb/tb_weight_rom_arbiter.sv
// Drives four arbiters (ROM_LAT 1..4) with identical stimulus and checks every
// output against a cycle-level reference model of the arbitration rules.
module tb_weight_rom_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 192;
  localparam int NL    = 4;
  localparam int DEPTH = 453;
  localparam int MAXB  = 16;
  localparam int HIST  = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;

  logic [NL-1:0] gnt0_w, gnt1_w, rv0_w, rv1_w, en_w, err_w;
  logic [AW-1:0] raddr_w    [NL];
  logic [DW-1:0] rdata_w    [NL];
  logic [DW-1:0] rom_data_w [NL];

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [23:0] w;
    w = 24'(a) * 24'd40503 + 24'd17;
    return {8{w}};
  endfunction

  for (genvar gi = 0; gi < NL; gi++) begin : g_lat
    localparam int L = gi + 1;
    logic [DW-1:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= en_w[gi] ? rom_word(raddr_w[gi]) : '0;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign rom_data_w[gi] = pipe[L-1];

    weight_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(L),
                         .ROM_DEPTH(DEPTH), .MAX_BURST(MAXB)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .addr0    (addr0),
      .gnt0     (gnt0_w[gi]),
      .rvalid0  (rv0_w[gi]),
      .req1     (req1),
      .addr1    (addr1),
      .gnt1     (gnt1_w[gi]),
      .rvalid1  (rv1_w[gi]),
      .rom_en   (en_w[gi]),
      .rom_addr (raddr_w[gi]),
      .rom_data (rom_data_w[gi]),
      .rdata    (rdata_w[gi]),
      .err_range(err_w[gi])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: owner (-1 = none), burst count, round-robin pointer, issue history.
  int            own = -1;
  int            cnt = 0;
  bit            rr  = 1'b0;
  int            cyc = 0;
  bit            acc_v [HIST];
  bit            acc_p [HIST];
  logic [AW-1:0] acc_a [HIST];
  bit            m_en  = 1'b0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;

  task automatic check_zero(input string where);
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("%s gnt0 L%0d", where, k+1),    DW'(gnt0_w[k]), '0);
      chk($sformatf("%s gnt1 L%0d", where, k+1),    DW'(gnt1_w[k]), '0);
      chk($sformatf("%s rvalid0 L%0d", where, k+1), DW'(rv0_w[k]), '0);
      chk($sformatf("%s rvalid1 L%0d", where, k+1), DW'(rv1_w[k]), '0);
      chk($sformatf("%s rom_en L%0d", where, k+1),  DW'(en_w[k]), '0);
      chk($sformatf("%s rom_addr L%0d", where, k+1), DW'(raddr_w[k]), '0);
      chk($sformatf("%s err L%0d", where, k+1),     DW'(err_w[k]), '0);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    own = -1; cnt = 0; rr = 1'b0;
    m_en = 1'b0; m_err = 1'b0; m_addr = '0;
    for (int j = 0; j < HIST; j++) acc_v[j] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      cyc++;
      check_zero("in_reset");
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic r0, input logic [AW-1:0] a0,
                      input logic r1, input logic [AW-1:0] a1);
    int  g, j, oth;
    bit  e0, e1, ri, ro;
    logic [AW-1:0] ga;
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("rom_en c%0d L%0d", cyc, k+1),   DW'(en_w[k]), DW'(m_en));
      chk($sformatf("rom_addr c%0d L%0d", cyc, k+1), DW'(raddr_w[k]), DW'(m_addr));
      chk($sformatf("err c%0d L%0d", cyc, k+1),      DW'(err_w[k]), DW'(m_err));
      j = cyc - 2 - k;
      e0 = 1'b0; e1 = 1'b0;
      if (j >= 0 && acc_v[j]) begin
        e0 = !acc_p[j];
        e1 = acc_p[j];
      end
      chk($sformatf("rvalid0 c%0d L%0d", cyc, k+1), DW'(rv0_w[k]), DW'(e0));
      chk($sformatf("rvalid1 c%0d L%0d", cyc, k+1), DW'(rv1_w[k]), DW'(e1));
      if (e0 || e1)
        chk($sformatf("rdata c%0d L%0d", cyc, k+1), rdata_w[k], rom_word(acc_a[j]));
    end

    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;

    g = -1;
    if (own < 0) begin
      if (r0 && r1)  g = int'(rr);
      else if (r0)   g = 0;
      else if (r1)   g = 1;
      if (g >= 0) begin own = g; cnt = 1; end
    end else begin
      oth = 1 - own;
      ri  = (own == 1) ? r1 : r0;
      ro  = (own == 1) ? r0 : r1;
      if (ri) begin
        if (cnt < MAXB) begin g = own; cnt++; end
        else if (ro)    begin g = oth; rr = (own == 1); own = oth; cnt = 1; end
        else            g = own;
      end else begin
        rr = (oth == 1);
        if (ro) begin g = oth; own = oth; cnt = 1; end
        else    begin own = -1; cnt = 0; end
      end
    end

    for (int k = 0; k < NL; k++) begin
      chk($sformatf("gnt0 c%0d L%0d", cyc, k+1), DW'(gnt0_w[k]), DW'(g == 0));
      chk($sformatf("gnt1 c%0d L%0d", cyc, k+1), DW'(gnt1_w[k]), DW'(g == 1));
    end

    acc_v[cyc] = (g >= 0);
    if (g >= 0) begin
      ga = (g == 1) ? a1 : a0;
      acc_p[cyc] = (g == 1);
      acc_a[cyc] = ga;
      m_en   = 1'b1;
      m_addr = ga;
      if (int'(ga) >= DEPTH) m_err = 1'b1;
      $display("txn c%0d port%0d addr %0d", cyc, g, ga);
    end else begin
      m_en = 1'b0;
    end
  endtask

  initial begin
    bit r0s, r1s;
    req0 = 1'b1; req1 = 1'b1;
    #2;
    reset_dut();

    // Single port burst from IDLE, then drain the returns.
    step(1'b1, 9'd0, 1'b0, 9'd0);
    step(1'b1, 9'd1, 1'b0, 9'd0);
    step(1'b1, 9'd2, 1'b0, 9'd0);
    repeat (6) step(1'b0, 9'd0, 1'b0, 9'd0);

    // Simultaneous start after reset: burst caps alternate ownership.
    reset_dut();
    for (int i = 0; i < 52; i++) step(1'b1, AW'(i), 1'b1, AW'(200 + i));
    // Port 1 owns and releases while port 0 waits.
    step(1'b1, 9'd7, 1'b0, 9'd0);
    step(1'b0, 9'd0, 1'b0, 9'd0);
    step(1'b1, 9'd11, 1'b1, 9'd22);
    repeat (6) step(1'b0, 9'd0, 1'b0, 9'd0);

    // Out-of-range address: sticky error, read still returned.
    step(1'b0, 9'd0, 1'b1, 9'd460);
    repeat (8) step(1'b0, 9'd0, 1'b0, 9'd0);

    // Reset with reads in flight.
    for (int i = 0; i < 6; i++) step(1'b1, AW'(30 + i), 1'b1, AW'(300 + i));
    reset_dut();
    step(1'b1, 9'd5, 1'b1, 9'd6);
    repeat (8) step(1'b0, 9'd0, 1'b0, 9'd0);

    // Randomized bursts with occasional out-of-range addresses.
    r0s = 1'b0; r1s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) r0s = !r0s;
      if ($urandom_range(0, 7) == 0) r1s = !r1s;
      step(r0s, AW'($urandom_range(0, 470)), r1s, AW'($urandom_range(0, 470)));
    end
    repeat (8) step(1'b0, 9'd0, 1'b0, 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
